shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: WIDTH, 16, data width; all requirements below are stated for 16.
REQ-002 Parameter: CNT_W, 5, shift-amount width taken from the low bits of B.
REQ-003 Port: clk  input  1  single clock, rising-edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  request; accepted on a rising edge when busy=0.
REQ-006 Port: op  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL (see Configuration).
REQ-007 Port: A  input  16  operand.
REQ-008 Port: B  input  16  shift amount; only B[4:0] is used (N = 0..31).
REQ-009 Port: busy  output  1  high while in state SHIFT.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: Y  output  16  registered result.
REQ-012 Port: OF  output  1  registered overflow flag, equal to A[15] XOR Y[15].
REQ-013 Port: err  output  1  one-cycle pulse, coincident with done, on an unsupported op.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL latch A, op and N, load Y=A, capture A[15], and set cnt=N.
REQ-016 On acceptance, the next state SHALL be SHIFT if N>0, otherwise DONE.
REQ-017 In SHIFT, each rising edge SHALL apply a one-bit step to Y and decrement cnt.
REQ-018 SHIFT SHALL transition to DONE on the edge where cnt reaches 0.
REQ-019 LSL step: Y <= {Y[14:0],0}.
REQ-020 LSR step: Y <= {0,Y[15:1]}.
REQ-021 ASR step: Y <= {Y[15],Y[15:1]}.
REQ-022 ROL step: Y <= {Y[14:0],Y[15]}.
REQ-023 N >= 16 SHALL NOT be saturated: all N steps execute, giving 0x0000 for LSL/LSR and sign fill for ASR.
REQ-024 Latency: done SHALL be high in the cycle after the (N+1)th rising edge, counting the accepting edge as the first.
REQ-025 done SHALL be high for exactly one cycle, and only in state DONE.
REQ-026 Without a new start, DONE SHALL go to IDLE.
REQ-027 start in DONE SHALL be accepted (back-to-back operation), with done still pulsing for the finished operation.
REQ-028 start while busy=1 SHALL be ignored, with no effect on state, Y, cnt or the latched op.
REQ-029 OF SHALL be updated on entry to DONE as captured A[15] XOR the final Y[15].
REQ-030 OF SHALL be held until the next accepted start clears it to 0.
REQ-031 Y SHALL be held stable from done until the next accepted start.
REQ-032 busy SHALL equal (state==SHIFT); it SHALL be 0 in IDLE and DONE.

Reset
REQ-033 rst=1 SHALL immediately force state=IDLE, cnt=0, Y=0x0000, OF=0, done=0, err=0 and busy=0, regardless of clk.
REQ-034 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-035 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-036 The macro SHIFT_SEQ_ROTATE_EN SHALL control support for op=11.
REQ-037 With SHIFT_SEQ_ROTATE_EN defined, op=11 SHALL perform ROL per REQ-022, with err=0.
REQ-038 Without SHIFT_SEQ_ROTATE_EN, op=11 SHALL be accepted but go directly to DONE with Y=A, OF=0 and err=1 coincident with done, for any N.

Verification
REQ-039 LSL, A=0x4001, N=1 -> done after 2 edges, Y=0x8002, OF=1.
REQ-040 ASR, A=0x8000, N=3 -> done after 4 edges, Y=0xF000, OF=0; LSR with the same A and N -> Y=0x1000, OF=1.
REQ-041 LSR, A=0x8000, N=20 -> busy for 20 cycles, Y=0x0000, OF=1; N=0 with A=0x1234 -> done on the next cycle, Y=0x1234, OF=0.
REQ-042 Start pulsed during busy with different A and op -> ignored, and the original result is produced on schedule; start during DONE -> done pulses, then the second operation proceeds.
REQ-043 Asserting rst mid-SHIFT on LSL, A=0xFFFF, N=10 -> all outputs are 0 immediately, with no done pulse.
REQ-044 op=11, A=0x8001, N=4 -> Y=0x0018, err=0 with SHIFT_SEQ_ROTATE_EN; without it -> done on the next cycle, Y=0x8001, err=1.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle one-bit-per-clock shifter (LSL/LSR/ASR, optional ROL) with done/err pulses.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN enables op=11 as rotate-left; otherwise op=11 is flagged via err.
module shift_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             OF,
  output logic             err
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   w_y_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [1:0]         r_op;
  logic [1:0]         w_op_nxt;
  logic               r_sign;
  logic               w_sign_nxt;
  logic               r_of;
  logic               w_of_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   w_step;
  logic [CNT_W-1:0]   w_n;
  logic               w_unsup;
  logic               w_unused_b;

  assign w_n        = B[CNT_W-1:0];
  assign w_unused_b = ^B[WIDTH-1:CNT_W];

`ifdef SHIFT_SEQ_ROTATE_EN
  assign w_unsup = 1'b0;
`else
  assign w_unsup = (op == OP_ROL);
`endif

  // One-bit step applied to the working result each SHIFT cycle
  always_comb begin
    w_step = r_y;
    case (r_op)
      OP_LSL:  w_step = {r_y[WIDTH-2:0], 1'b0};
      OP_LSR:  w_step = {1'b0, r_y[WIDTH-1:1]};
      OP_ASR:  w_step = {r_y[WIDTH-1], r_y[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROL:  w_step = {r_y[WIDTH-2:0], r_y[WIDTH-1]};
`else
      OP_ROL:  w_step = r_y;
`endif
      default: w_step = r_y;
    endcase
  end

  // Next-state and next-register logic
  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_sign_nxt  = r_sign;
    w_of_nxt    = r_of;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_y_nxt    = A;
          w_op_nxt   = op;
          w_sign_nxt = A[WIDTH-1];
          w_cnt_nxt  = w_n;
          w_of_nxt   = 1'b0;
          if (w_unsup) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = DONE;
          end else if (w_n != '0) begin
            w_state_nxt = SHIFT;
          end else begin
            w_state_nxt = DONE;
          end
        end else if (r_state == DONE) begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        w_y_nxt   = w_step;
        w_cnt_nxt = CNT_W'(r_cnt - CNT_W'(1));
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = DONE;
          w_of_nxt    = r_sign ^ w_step[WIDTH-1];
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_y     <= '0;
      r_cnt   <= '0;
      r_op    <= OP_LSL;
      r_sign  <= 1'b0;
      r_of    <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_sign  <= w_sign_nxt;
      r_of    <= w_of_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt == SHIFT);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Y    = r_y;
  assign OF   = r_of;
  assign err  = r_err;

endmodule
